// File: rtl/spm_dma_ctrl_if.sv
// SPM port-B style bus: active-low address strobe, rw (1 = read, 0 = write),
// write data, and read data returned one cycle after the address.
interface spm_dma_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (output addr, as_, rw, wr_data, input  rd_data);
    modport slave  (input  addr, as_, rw, wr_data, output rd_data);
endinterface

// File: rtl/spm_dma_ctrl.sv
// Block-copy engine stealing idle SPM port-B cycles from the MEM stage.
// Optional fill mode (constant pattern writes) is enabled by SPM_DMA_FILL_EN.
module spm_dma_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_src,
    input  logic [ADDR_W-1:0] dma_dst,
    input  logic [LEN_W-1:0]  dma_len,
`ifdef SPM_DMA_FILL_EN
    input  logic              dma_fill,
    input  logic [DATA_W-1:0] dma_fill_data,
`endif
    output logic              dma_busy,
    output logic              dma_done,
    spm_dma_ctrl_if.slave     mem,
    spm_dma_ctrl_if.master    spm
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic             RW_READ  = 1'b1;
    localparam logic             RW_WRITE = 1'b0;
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [DATA_W-1:0] buf_r;
    logic              fill_mode_r;
    logic              busy_r;
    logic              done_r;
    logic              fill_start_s;
    logic [DATA_W-1:0] fill_data_s;
    logic              port_free_s;
    logic              start_s;
    logic              last_s;
    logic              dma_req_s;
    logic              dma_rw_s;
    logic [ADDR_W-1:0] dma_addr_s;
    logic [DATA_W-1:0] dma_wdata_s;

`ifdef SPM_DMA_FILL_EN
    assign fill_start_s = dma_fill;
    assign fill_data_s  = dma_fill_data;
`else
    assign fill_start_s = 1'b0;
    assign fill_data_s  = {DATA_W{1'b0}};
`endif

    // A DMA request is granted only in cycles the MEM stage leaves the port idle.
    assign port_free_s = mem.as_;
    assign start_s     = (state_r == ST_IDLE) && dma_start;
    assign last_s      = ((cnt_r + LEN_ONE) == len_r);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dma_start) begin
                    if (dma_len == {LEN_W{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else if (fill_start_s) begin
                        state_next_s = ST_WR;
                    end else begin
                        state_next_s = ST_RD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (port_free_s) begin
                    state_next_s = ST_CAP;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_CAP:  state_next_s = ST_WR;
            ST_WR: begin
                if (!port_free_s) begin
                    state_next_s = ST_WR;
                end else if (last_s) begin
                    state_next_s = ST_DONE;
                end else if (fill_mode_r) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Transfer parameters, word counter and word buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_r       <= {ADDR_W{1'b0}};
            dst_r       <= {ADDR_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            buf_r       <= {DATA_W{1'b0}};
            fill_mode_r <= 1'b0;
        end else if (start_s) begin
            src_r       <= dma_src;
            dst_r       <= dma_dst;
            len_r       <= dma_len;
            cnt_r       <= {LEN_W{1'b0}};
            fill_mode_r <= fill_start_s;
            if (fill_start_s) begin
                buf_r <= fill_data_s;
            end
        end else if (state_r == ST_CAP) begin
            buf_r <= spm.rd_data;
        end else if ((state_r == ST_WR) && port_free_s) begin
            cnt_r <= cnt_r + LEN_ONE;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign dma_busy = busy_r;
    assign dma_done = done_r;

    // DMA port request decoded from the state; addresses wrap modulo 2^ADDR_W.
    always_comb begin
        dma_req_s   = 1'b0;
        dma_rw_s    = RW_READ;
        dma_addr_s  = {ADDR_W{1'b0}};
        dma_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            ST_RD: begin
                dma_req_s  = 1'b1;
                dma_rw_s   = RW_READ;
                dma_addr_s = src_r + cnt_r[ADDR_W-1:0];
            end
            ST_WR: begin
                dma_req_s   = 1'b1;
                dma_rw_s    = RW_WRITE;
                dma_addr_s  = dst_r + cnt_r[ADDR_W-1:0];
                dma_wdata_s = buf_r;
            end
            default: begin
                dma_req_s = 1'b0;
            end
        endcase
    end

    // Port B mux: the MEM stage always wins.
    always_comb begin
        if (!mem.as_) begin
            spm.addr    = mem.addr;
            spm.as_     = mem.as_;
            spm.rw      = mem.rw;
            spm.wr_data = mem.wr_data;
        end else begin
            spm.addr    = dma_addr_s;
            spm.as_     = ~dma_req_s;
            spm.rw      = dma_rw_s;
            spm.wr_data = dma_wdata_s;
        end
    end

    assign mem.rd_data = spm.rd_data;

endmodule

// File: doc/spm_dma_ctrl.md
# spm_dma_ctrl

Block-copy engine that shares SPM port B with the CPU MEM stage. It sits between the MEM stage and the dual-port SPM RAM. It moves `len` words from a source SPM address to a destination SPM address using only cycles in which the MEM stage leaves port B idle. The MEM stage always has priority and is never stalled; the engine reports `busy`/`done` to the CPU.

## Interface
Parameters:
- `ADDR_W`, 12: SPM word-address width (4096 words).
- `DATA_W`, 32: SPM word width.
- `LEN_W`, `ADDR_W+1`: transfer length width (0..4096).

Ports (`as_` is active-low; rw `READ`=1, `WRITE`=0):
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dma_start`  in  1  one-cycle start pulse.
- `dma_src`  in  ADDR_W  source word address, latched on start.
- `dma_dst`  in  ADDR_W  destination word address, latched on start.
- `dma_len`  in  LEN_W  word count, latched on start.
- `dma_fill`  in  1  1 = fill mode (only with `SPM_DMA_FILL_EN`).
- `dma_fill_data`  in  DATA_W  fill pattern (only with `SPM_DMA_FILL_EN`).
- `dma_busy`  out  1  transfer in progress.
- `dma_done`  out  1  one-cycle completion pulse.
- `mem_spm_addr`, `mem_spm_as_`, `mem_spm_rw`, `mem_spm_wr_data`  in  ADDR_W/1/1/DATA_W  MEM-stage request.
- `mem_spm_rd_data`  out  DATA_W  equals `spm_rd_data`, passed through.
- `spm_addr`, `spm_as_`, `spm_rw`, `spm_wr_data`  out  ADDR_W/1/1/DATA_W  to SPM port B.
- `spm_rd_data`  in  DATA_W  SPM port B read data, valid one cycle after the address.

## Operation
- **Port mux (combinational):**
  - If `mem_spm_as_`=0, all four `spm_*` outputs equal the MEM inputs.
  - Otherwise they carry the DMA request.
  - With no DMA request, `spm_as_`=1, `spm_rw`=READ, `spm_addr`=0, `spm_wr_data`=0.
- **FSM states:** IDLE, RD, CAP, WR, DONE.
  - IDLE: on `dma_start`, latch src/dst/len, clear the word counter, and go to RD. If len=0, go to DONE instead.
  - RD: request a read at `src+cnt` (`spm_as_`=0, READ). The request is accepted only when `mem_spm_as_`=1; on acceptance go to CAP, otherwise hold.
  - CAP: capture `spm_rd_data` into a word buffer unconditionally. CAP makes no port request, so the MEM stage may use the port this cycle. Then go to WR.
  - WR: request a write of the buffer to `dst+cnt`. On acceptance (`mem_spm_as_`=1), increment `cnt`. If `cnt+1==len`, go to DONE; otherwise go to RD.
  - DONE: `dma_done`=1 for exactly one cycle, then go to IDLE.
- `dma_busy`=1 in every state except IDLE.
- **Address arithmetic:** `src+cnt` and `dst+cnt` are computed modulo 2^ADDR_W, so addresses wrap from 4095 to 0.
- Words are copied in ascending order. For overlapping ranges with dst > src, earlier-written words are re-read; this replication is the defined behaviour.
- `dma_start` while `dma_busy`=1 is ignored; the latched parameters are unchanged.
- **Reset mid-transfer:** the FSM returns to IDLE immediately. Words already written stay written; no `dma_done` pulse is produced.

## Timing
- **Reset values:** `dma_busy`=0, `dma_done`=0, FSM in IDLE, counter and buffer 0. The `spm_*` outputs follow the MEM inputs.
- **Start:** start pulse at cycle T puts the FSM in RD at T+1.
- **Copy rate with MEM idle:** 3 cycles per word (RD, CAP, WR). For len=N, `dma_done` is high at cycle T+3N+1, and `dma_busy` is high from T+1 through T+3N+1.
- Each cycle in which the MEM stage takes the port during RD or WR adds one cycle. MEM accesses during CAP cost nothing.
- **len=0:** `dma_done` is high at T+1; no SPM access occurs.
- **Read latency:** `mem_spm_rd_data` keeps the RAM's one-cycle latency. A DMA access in the cycle after a MEM read does not corrupt that read's data.

## Configuration
- **`SPM_DMA_FILL_EN` defined:**
  - The `dma_fill` and `dma_fill_data` ports exist.
  - On start with `dma_fill`=1, the fill pattern is latched and the FSM runs IDLE→WR→…→DONE, skipping RD and CAP. Each word writes the pattern to `dst+cnt`.
  - Fill mode runs at 1 cycle per word; len=N gives `dma_done` at T+N+1.
- **Macro undefined:** both ports are absent and only copy mode exists.

## Test plan
- Copy src=0x010, dst=0x200, len=4 with MEM idle → four writes to 0x200..0x203 with source data; `dma_done` at T+13; `dma_busy` 12 cycles plus the DONE cycle.
- Same copy with `mem_spm_as_`=0 held 5 cycles during the first RD → MEM request appears on `spm_*` each of those cycles; `dma_done` is delayed to T+18; data is correct.
- src=0xFFE, dst=0x000, len=3 → reads 0xFFE, 0xFFF, 0x000; writes 0x000..0x002.
- len=0 → `dma_done` at T+1, `spm_as_` stays 1. A `dma_start` during an active copy is ignored.
- `reset` asserted after 2 words of a len=8 copy → `dma_busy`=0 immediately, no `dma_done`, only 2 destination words modified.
- With `SPM_DMA_FILL_EN`: fill dst=0x100, len=4, pattern 0xDEADBEEF → 0x100..0x103 = 0xDEADBEEF; `dma_done` at T+5.
